// File: rtl/inv_cipher_core.sv
// inv_cipher_core: iterative AES-128 inverse cipher, one round per clock, with an on-the-fly inverse key schedule
// Ports: Clk_CI clock; Reset_RBI synchronous active-low reset; Start_SI start request, taken only when idle;
//   Ciphertext_DI / LastRoundkey_DI block and round-10 key, sampled at the start edge;
//   Busy_SO decryption in progress; Valid_SO one-cycle result strobe; Plaintext_DO registered plaintext.
module inv_cipher_core (
  input  logic         Clk_CI,
  input  logic         Reset_RBI,
  input  logic         Start_SI,
  input  logic [127:0] Ciphertext_DI,
  input  logic [127:0] LastRoundkey_DI,
  output logic         Busy_SO,
  output logic         Valid_SO,
  output logic [127:0] Plaintext_DO
);
  typedef enum logic {IDLE, RUN} fsmState_t;
  fsmState_t fsmQ, fsmD;
  logic [3:0] rndQ, rndD;
  logic [127:0] stateQ, stateD, keyQ, keyD, plainD, rkPrev, mixIn;
  logic validD;
  logic [31:0] w0, w1, w2, w3, subRot;
  logic [7:0] rcon;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, as the S-box needs
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gfMul(p, p);
      r = gfMul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gfInv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] invSbox(input logic [7:0] a);
    return gfInv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction
  // byte (r,c) sits at bits [127-8*(r+4c) -: 8]; row r rotates right by r columns
  function automatic logic [127:0] invShiftSub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = invSbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] invMixCols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
      o[119-32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
      o[111-32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
      o[103-32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
    end
    return o;
  endfunction
  // keyQ holds rk(rndQ+1), so stepping back to rk(rndQ) uses Rcon(rndQ+1)
  always_comb begin
    rcon = rndQ < 4'd8 ? 8'h01 << rndQ : (rndQ == 4'd8 ? 8'h1b : 8'h36);
    w3 = keyQ[31:0] ^ keyQ[63:32];
    w2 = keyQ[63:32] ^ keyQ[95:64];
    w1 = keyQ[95:64] ^ keyQ[127:96];
    subRot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = keyQ[127:96] ^ subRot ^ {rcon, 24'h0};
    rkPrev = {w0, w1, w2, w3};
    mixIn = invShiftSub(stateQ) ^ rkPrev;
  end
  always_comb begin
    fsmD = fsmQ;
    rndD = rndQ;
    stateD = stateQ;
    keyD = keyQ;
    plainD = Plaintext_DO;
    validD = 1'b0;
    if (fsmQ == IDLE) begin
      if (Start_SI) begin
        fsmD = RUN;
        rndD = 4'd9;
        stateD = Ciphertext_DI ^ LastRoundkey_DI;
        keyD = LastRoundkey_DI;
      end
    end else if (rndQ != 4'd0) begin
      stateD = invMixCols(mixIn);
      keyD = rkPrev;
      rndD = rndQ - 4'd1;
    end else begin
      plainD = mixIn;
      validD = 1'b1;
      fsmD = IDLE;
    end
  end
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      fsmQ <= IDLE;
      rndQ <= '0;
      stateQ <= '0;
      keyQ <= '0;
      Plaintext_DO <= '0;
      Valid_SO <= 1'b0;
    end else begin
      fsmQ <= fsmD;
      rndQ <= rndD;
      stateQ <= stateD;
      keyQ <= keyD;
      Plaintext_DO <= plainD;
      Valid_SO <= validD;
    end
  end
  assign Busy_SO = fsmQ == RUN;
endmodule

// File: doc/inv_cipher_core.md
INV_CIPHER_CORE -- requirements
Module: inv_cipher_core

Interface
REQ-001 The block SHALL have no parameters; the AES-128 key size and 10 rounds are fixed.
REQ-002 Clk_CI  input  1  single clock; all registers update on its rising edge.
REQ-003 Reset_RBI  input  1  reset, synchronous, active-low.
REQ-004 Start_SI  input  1  request to start one decryption; sampled only when Busy_SO=0.
REQ-005 Ciphertext_DI  input  128  ciphertext block; bits [127:120] = state byte s(0,0), then column-major per FIPS-197.
REQ-006 LastRoundkey_DI  input  128  round-10 key of the expanded AES-128 schedule, same byte order as Ciphertext_DI.
REQ-007 Busy_SO  output  1  high while a decryption is in progress.
REQ-008 Valid_SO  output  1  one-cycle pulse marking Plaintext_DO as newly valid.
REQ-009 Plaintext_DO  output  128  decrypted block, same byte order; registered.

Function
REQ-010 The block SHALL implement the FIPS-197 inverse cipher iteratively, one round per clock, with an on-the-fly inverse key schedule.
REQ-011 The FSM SHALL have two states, IDLE and RUN, plus a 4-bit round counter Rnd and 128-bit State and Key registers.
REQ-012 IDLE with Start_SI=1 at edge E0: State <= Ciphertext_DI xor LastRoundkey_DI; Key <= LastRoundkey_DI; Rnd <= 9; go to RUN.
REQ-013 The inverse key step SHALL compute rk(r-1) from rk(r) = w0..w3: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon(r).
REQ-014 Rcon(r) for r=10..1 SHALL be 36,1b,80,40,20,10,08,04,02,01 (hex), placed in the most significant byte of the word.
REQ-015 RUN with Rnd>=1: State <= InvMixColumns(InvSubBytes(InvShiftRows(State)) xor rk(Rnd)); Key <= rk(Rnd); Rnd <= Rnd-1.
REQ-016 RUN with Rnd=0: Plaintext_DO <= InvSubBytes(InvShiftRows(State)) xor rk(0); Valid_SO <= 1; go to IDLE.
REQ-017 Latency: with Start_SI sampled at E0, rounds execute at E1..E10; Valid_SO SHALL be high in exactly the cycle after E10 (11 cycles after the start edge).
REQ-018 Busy_SO SHALL be high in the cycles after E0 through E10 and low in the Valid_SO cycle.
REQ-019 Valid_SO SHALL be high for exactly one cycle per completed decryption and never otherwise.
REQ-020 Start_SI while Busy_SO=1 SHALL be ignored, with no effect on the operation in progress or on outputs.
REQ-021 Start_SI=1 in the Valid_SO cycle SHALL be accepted (back-to-back); continuous Start_SI=1 yields one result every 11 cycles.
REQ-022 Ciphertext_DI and LastRoundkey_DI SHALL be sampled only at the start edge; later changes SHALL not affect the result.
REQ-023 Plaintext_DO SHALL change only at the completion edge and SHALL hold its value until the next completion or reset.
REQ-024 All byte transforms SHALL be purely combinational between registers; no multicycle paths.

Reset
REQ-025 Reset_RBI=0 at a rising edge SHALL force IDLE, Rnd=0, State=0, Key=0, Busy_SO=0, Valid_SO=0, Plaintext_DO=0, overriding any Start_SI.
REQ-026 Reset mid-operation SHALL abort the decryption with no Valid_SO pulse; the next Start_SI after release SHALL start a fresh operation with normal latency.
REQ-027 Reset release SHALL not itself cause any output activity.

Verification
REQ-028 FIPS-197 C.1: ct=69c4e0d86a7b0430d8cdb78070b4c55a, rk10=13111d7fe3944a17f307a78b4d2b30c5, one Start pulse -> Valid_SO exactly 11 cycles later, Plaintext_DO=00112233445566778899aabbccddeeff.
REQ-029 FIPS-197 App. B: ct=3925841d02dc09fbdc118597196a0b32, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 -> Plaintext_DO=3243f6a8885a308d313198a2e0370734.
REQ-030 Start C.1, then pulse Start_SI with the App. B vector at cycle 4 and randomize inputs while busy -> only the C.1 result appears, single Valid_SO, Busy_SO timing unchanged.
REQ-031 Start_SI held high with C.1 then App. B vectors presented at each start edge -> Valid_SO at cycles 11 and 22 with C.1 then App. B plaintexts, Busy_SO low only in Valid_SO cycles.
REQ-032 Start C.1, assert Reset_RBI=0 at cycle 5 for one cycle -> all outputs 0 next cycle, no Valid_SO; restart with App. B -> correct result 11 cycles after restart.
REQ-033 Random key/plaintext pairs (>=1000) encrypted by a reference model, rk10 supplied -> every Plaintext_DO matches the original plaintext.
